// File: rtl/hi_lo_unit.sv
// +--------------------------------------------------------------------------+
// | hi_lo_unit: MIPS HI/LO commit stage with multiply/divide issue latency   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hi_lo_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic        divisor_zero,
  input  logic [63:0] mult_div_result,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [31:0] pend_hi, pend_hi_next;
  logic [31:0] pend_lo, pend_lo_next;
  logic        pend_dz, pend_dz_next;
  logic [31:0] hi_next, lo_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      pend_dz <= pend_dz_next;
      hi      <= hi_next;
      lo      <= lo_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    pend_dz_next = pend_dz;
    hi_next      = hi;
    lo_next      = lo;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          // Divide arrives as {quotient, remainder}; HI takes the remainder.
          pend_hi_next = op_is_div ? mult_div_result[31:0]  : mult_div_result[63:32];
          pend_lo_next = op_is_div ? mult_div_result[63:32] : mult_div_result[31:0];
          pend_dz_next = op_is_div & divisor_zero;
          cnt_next     = op_is_div ? DIV_CNT : MULT_CNT;
          state_next   = S_BUSY;
        end else begin
          if (mthi) hi_next = mt_data;
          if (mtlo) lo_next = mt_data;
        end
      end
      S_BUSY: begin
        cnt_next = cnt - 8'd1;
        if (cnt == 8'd1) begin
          if (!pend_dz) begin
            hi_next = pend_hi;
            lo_next = pend_lo;
          end
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy     = (state == S_BUSY);
  assign rd_data  = rd_sel ? hi : lo;
  assign rd_valid = rd_req & ~busy;
  assign stall    = (op_valid | mthi | mtlo | rd_req) & busy;

endmodule

`default_nettype wire

// File: doc/hi_lo_unit.md
# hi_lo_unit

Multiply/divide completion stage of the MIPS CPU, sitting directly downstream of the ALU. It consumes the ALU's 64-bit multiply/divide result and commits it to the architectural HI and LO registers after a configurable issue latency. It serves MFHI/MFLO/MTHI/MTLO, and raises a stall to the pipeline control while a multiply or divide is in flight.

## Interface
Parameters:
- MULT_CYCLES, default 4: cycles from MULT/MULTU acceptance to HI/LO commit; legal range 1..255.
- DIV_CYCLES, default 12: cycles from DIV/DIVU acceptance to HI/LO commit; legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  a MULT/MULTU/DIV/DIVU result is presented this cycle.
- op_is_div  in  1  1 = divide, 0 = multiply; qualified by op_valid.
- divisor_zero  in  1  divisor operand equals 0; qualified by op_valid & op_is_div.
- mult_div_result  in  64  ALU_MULTorDIV_result. Multiply: {hi_word, lo_word}. Divide: {quotient, remainder}.
- mthi  in  1  write mt_data to HI.
- mtlo  in  1  write mt_data to LO.
- mt_data  in  32  source data for MTHI/MTLO.
- rd_req  in  1  MFHI/MFLO request.
- rd_sel  in  1  0 = LO, 1 = HI.
- rd_data  out  32  selected register; combinational from hi/lo and rd_sel.
- rd_valid  out  1  rd_req & ~busy.
- stall  out  1  (op_valid | mthi | mtlo | rd_req) & busy.
- busy  out  1  operation in flight (registered).
- hi  out  32  architectural HI (registered).
- lo  out  32  architectural LO (registered).

## Operation
- States: IDLE (busy = 0) and BUSY (busy = 1); down-counter cnt, width 8.
- In IDLE, with op_valid = 1 at an edge:
  - Capture pend_hi and pend_lo. Multiply: pend_hi = result[63:32], pend_lo = result[31:0]. Divide: pend_hi = result[31:0] (remainder), pend_lo = result[63:32] (quotient).
  - Capture pend_dz = op_is_div & divisor_zero.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to BUSY.
- In BUSY, cnt decrements each edge. At the edge where cnt == 1:
  - Commit pend_hi/pend_lo to hi/lo, unless pend_dz = 1, in which case hi/lo are left unchanged.
  - Return to IDLE.
- Any op_valid, mthi, mtlo or rd_req in BUSY asserts stall and has no effect. The requester holds the request until stall drops.
- Priority in IDLE: op_valid takes precedence over mthi/mtlo; an mthi/mtlo in the same cycle as op_valid is ignored.
- mthi and mtlo asserted together in IDLE: both registers get mt_data.
- A read in the same cycle as mthi/mtlo returns the pre-write value; the write lands at the edge.
- Signedness is not handled here: the ALU resolves signed vs unsigned before this stage.

## Timing
- Reset: hi = 0, lo = 0, busy = 0, cnt = 0, pend_* = 0; stall = 0 and rd_valid follows rd_req.
- Reset asserted mid-operation aborts the operation; nothing is committed.
- Reset has priority over all inputs at the same edge.
- Latency: op accepted at edge E0 → busy = 1 from after E0 → hi/lo updated and busy = 0 after edge E0 + N (N = MULT_CYCLES or DIV_CYCLES). busy is high for exactly N cycles.
- Back-to-back: a new op may be accepted at the first edge where busy = 0, i.e. the cycle after commit. Commit and new issue never share an edge.
- MTHI/MTLO in IDLE: hi/lo update at the next edge; zero latency to busy.
- rd_data is combinational. It reflects committed values only; there is no bypass of pending results.

## Test plan
- Reset then idle: hi = 0, lo = 0, busy = 0. rd_req = 1, rd_sel = 1 → rd_valid = 1, rd_data = 0.
- MULT (-3 × 5): mult_div_result = 64'hFFFFFFFF_FFFFFFF1, op_is_div = 0 → busy = 1 for 4 cycles, then hi = 32'hFFFFFFFF, lo = 32'hFFFFFFF1. rd_req during busy → stall = 1, rd_valid = 0.
- DIV 17/5: mult_div_result = 64'h00000003_00000002 → after exactly 12 cycles lo = 3, hi = 2.
- Divide by zero: preload hi = 32'hAAAA0000, lo = 32'h0000BBBB via MTHI/MTLO, then op_valid with divisor_zero = 1 → busy for 12 cycles, hi/lo unchanged.
- MTHI 32'h12345678 during busy: stall = 1 and hi unchanged. After commit, the same request writes hi = 32'h12345678 one edge later.
- Reset asserted at cycle 2 of a DIV: busy = 0, hi = lo = 0 next cycle, and no commit occurs at the original completion edge.
